// File: rtl/wb_pkg.sv
// Shared types and constants for the RV32I writeback stage.
package wb_pkg;

    typedef enum logic [1:0] {
        ALU  = 2'd0,
        LOAD = 2'd1,
        PC4  = 2'd2,
        CSR  = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction: picks the byte/half/word out of the aligned memory
// word, extends it, and flags illegal funct3 or misaligned accesses.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            fault
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Extract, extend and fault-check the addressed load lane.
    always_comb begin
        byte_sel = rdata[8*addr_lo +: 8];
        half_sel = rdata[16*addr_lo[1] +: 16];
        data     = '0;
        fault    = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data  = {{(XLEN-16){half_sel[15]}}, half_sel};
                fault = addr_lo[0];
            end
            F3_LHU: begin
                data  = {{(XLEN-16){1'b0}}, half_sel};
                fault = addr_lo[0];
            end
            F3_LW: begin
                data  = rdata;
                fault = (addr_lo != 2'd0);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts retiring instructions, waits for load responses,
// and drives a registered register-file write port.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_we,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [XLEN-1:0] in_csr_rdata,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            flush,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            pend_valid,
    output logic [4:0]      pend_rd,
    output logic            load_fault
);

    wb_state_e       state;
    logic            lat_we;
    logic [4:0]      lat_rd;
    logic [2:0]      lat_funct3;
    logic [1:0]      lat_addr_lo;
    logic [XLEN-1:0] src_data;
    logic [XLEN-1:0] acc_data_unused;
    logic            acc_fault;
    logic [XLEN-1:0] ld_data;
    logic            ld_fault_unused;

    assign in_ready   = (state == IDLE);
    assign pend_valid = (state == WAIT);
    assign pend_rd    = lat_rd;

    // Acceptance-time check on the incoming load fields.
    load_align #(.XLEN(XLEN)) u_acc_check (
        .funct3  (in_funct3),
        .addr_lo (in_addr_lo),
        .rdata   (dmem_rdata),
        .data    (acc_data_unused),
        .fault   (acc_fault)
    );

    // Data extraction on the latched load fields.
    load_align #(.XLEN(XLEN)) u_ld_data (
        .funct3  (lat_funct3),
        .addr_lo (lat_addr_lo),
        .rdata   (dmem_rdata),
        .data    (ld_data),
        .fault   (ld_fault_unused)
    );

    // Non-load writeback source select.
    always_comb begin
        src_data = in_alu_result;
        case (wb_sel_e'(in_wb_sel))
            PC4:     src_data = in_pc4;
            CSR:     src_data = in_csr_rdata;
            default: src_data = in_alu_result;
        endcase
    end

    // FSM, latched load fields and registered write port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_rd      <= '0;
            lat_funct3  <= '0;
            lat_addr_lo <= '0;
            rf_we       <= 1'b0;
            rf_rd       <= '0;
            rf_wdata    <= '0;
            load_fault  <= 1'b0;
        end else begin
            rf_we      <= 1'b0;
            load_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        if (wb_sel_e'(in_wb_sel) == LOAD) begin
                            if (acc_fault) begin
                                load_fault <= 1'b1;
                            end else begin
                                lat_we      <= in_we;
                                lat_rd      <= in_rd;
                                lat_funct3  <= in_funct3;
                                lat_addr_lo <= in_addr_lo;
                                state       <= WAIT;
                            end
                        end else begin
                            rf_we    <= in_we && (in_rd != 5'd0);
                            rf_rd    <= in_rd;
                            rf_wdata <= src_data;
                        end
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= dmem_rvalid ? IDLE : DRAIN;
                    end else if (dmem_rvalid) begin
                        rf_we    <= lat_we && (lat_rd != 5'd0);
                        rf_rd    <= lat_rd;
                        rf_wdata <= ld_data;
                        state    <= IDLE;
                    end
                end
                DRAIN: begin
                    if (dmem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_we;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc4;
    logic [31:0] in_csr_rdata;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        load_fault;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_we         (in_we),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc4        (in_pc4),
        .in_csr_rdata  (in_csr_rdata),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .flush         (flush),
        .rf_we         (rf_we),
        .rf_rd         (rf_rd),
        .rf_wdata      (rf_wdata),
        .pend_valid    (pend_valid),
        .pend_rd       (pend_rd),
        .load_fault    (load_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] lo);
        in_valid  = 1'b1;
        in_we     = 1'b1;
        in_wb_sel = sel;
        in_rd     = rd;
        in_funct3 = f3;
        in_addr_lo = lo;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_rd = '0; in_wb_sel = '0;
        in_alu_result = '0; in_pc4 = '0; in_csr_rdata = '0; in_funct3 = '0;
        in_addr_lo = '0; dmem_rvalid = 1'b0; dmem_rdata = '0; flush = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_pend_valid", pend_valid, 0);
        chk("rst_pend_rd", pend_rd, 0);
        chk("rst_load_fault", load_fault, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;

        // Back-to-back ALU writes
        present(2'd0, 5'd5, 3'd0, 2'd0); in_alu_result = 32'h0000_1234;
        tick();
        chk("alu1_we", rf_we, 1);
        chk("alu1_rd", rf_rd, 5);
        chk("alu1_wdata", rf_wdata, 32'h0000_1234);
        in_rd = 5'd6; in_alu_result = 32'h0000_0055;
        tick();
        chk("alu2_we", rf_we, 1);
        chk("alu2_rd", rf_rd, 6);
        chk("alu2_wdata", rf_wdata, 32'h0000_0055);
        in_valid = 1'b0;
        tick();
        chk("idle_we", rf_we, 0);
        chk("idle_rd_hold", rf_rd, 6);
        chk("idle_wdata_hold", rf_wdata, 32'h0000_0055);

        // PC+4 and CSR sources
        present(2'd2, 5'd3, 3'd0, 2'd0); in_pc4 = 32'h0000_0104;
        tick();
        chk("pc4_wdata", rf_wdata, 32'h0000_0104);
        in_wb_sel = 2'd3; in_rd = 5'd4; in_csr_rdata = 32'h0000_0ABC;
        tick();
        chk("csr_wdata", rf_wdata, 32'h0000_0ABC);
        chk("csr_rd", rf_rd, 4);
        in_valid = 1'b0;

        // LB, addr_lo=3, response two cycles after acceptance
        present(2'd1, 5'd7, 3'd0, 2'd3);
        tick();
        in_valid = 1'b0;
        chk("lb_wait_ready", in_ready, 0);
        chk("lb_pend_valid", pend_valid, 1);
        chk("lb_pend_rd", pend_rd, 7);
        chk("lb_wait_we", rf_we, 0);
        tick();
        chk("lb_wait2_pend", pend_valid, 1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h80AB_CDEF;
        tick();
        dmem_rvalid = 1'b0;
        chk("lb_we", rf_we, 1);
        chk("lb_rd", rf_rd, 7);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        chk("lb_ready_back", in_ready, 1);
        chk("lb_pend_clear", pend_valid, 0);

        // LBU same access, minimum occupancy
        present(2'd1, 5'd8, 3'd4, 2'd3);
        tick();
        in_valid = 1'b0;
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        chk("lbu_we", rf_we, 1);
        chk("lbu_wdata", rf_wdata, 32'h0000_0080);

        // LH, addr_lo=2
        present(2'd1, 5'd9, 3'd1, 2'd2);
        tick();
        in_valid = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h9234_5678;
        tick();
        dmem_rvalid = 1'b0;
        chk("lh_wdata", rf_wdata, 32'hFFFF_9234);
        chk("lh_rd", rf_rd, 9);

        // Misaligned LW
        present(2'd1, 5'd10, 3'd2, 2'd1);
        tick();
        in_valid = 1'b0;
        chk("lw_mis_fault", load_fault, 1);
        chk("lw_mis_we", rf_we, 0);
        chk("lw_mis_ready", in_ready, 1);
        tick();
        chk("fault_one_cycle", load_fault, 0);

        // Illegal funct3
        present(2'd1, 5'd10, 3'd3, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("f3_illegal_fault", load_fault, 1);
        chk("f3_illegal_ready", in_ready, 1);

        // ALU write to x0 suppressed
        present(2'd0, 5'd0, 3'd0, 2'd0); in_alu_result = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        chk("x0_alu_we", rf_we, 0);

        // Load to x0: waits, no write
        present(2'd1, 5'd0, 3'd2, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("x0_ld_wait", in_ready, 0);
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        chk("x0_ld_we", rf_we, 0);
        chk("x0_ld_ready", in_ready, 1);

        // Flush in WAIT, response three cycles later
        present(2'd1, 5'd11, 3'd2, 2'd0);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_ready", in_ready, 0);
        chk("drain_pend", pend_valid, 0);
        chk("drain_we0", rf_we, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_flush_ignored", in_ready, 0);
        chk("drain_we1", rf_we, 0);
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        chk("drain_we2", rf_we, 0);
        chk("drain_done_ready", in_ready, 1);

        // Flush coincident with response
        present(2'd1, 5'd12, 3'd2, 2'd0);
        tick();
        in_valid = 1'b0;
        flush = 1'b1; dmem_rvalid = 1'b1;
        tick();
        flush = 1'b0; dmem_rvalid = 1'b0;
        chk("flush_rv_we", rf_we, 0);
        chk("flush_rv_ready", in_ready, 1);

        // Flush in acceptance cycle
        present(2'd0, 5'd13, 3'd0, 2'd0); in_alu_result = 32'h0000_0777;
        flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc_we", rf_we, 0);
        chk("flush_acc_ready", in_ready, 1);

        // Reset during WAIT, stale response afterwards
        present(2'd1, 5'd14, 3'd2, 2'd0);
        tick();
        in_valid = 1'b0;
        chk("rstw_pend", pend_rd, 14);
        reset_n = 1'b0;
        tick();
        chk("rstw_ready", in_ready, 1);
        chk("rstw_pend_valid", pend_valid, 0);
        chk("rstw_pend_rd", pend_rd, 0);
        chk("rstw_rf_rd", rf_rd, 0);
        chk("rstw_rf_wdata", rf_wdata, 0);
        reset_n = 1'b1;
        dmem_rvalid = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        chk("stale_rv_we", rf_we, 0);
        chk("stale_rv_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I core. It accepts one retiring instruction per handshake from the MEM stage and waits for the data-memory response on loads. It aligns and sign/zero-extends load data, selects the writeback source, and drives the register-file write port. The register file commits on the falling clock edge, so every `rf_*` output here is registered on the rising edge and held stable for the whole cycle.

## Interface
- `XLEN`, default 32: datapath width.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: MEM stage presents an instruction.
- `in_ready` out 1: stage can accept; equals (state == IDLE).
- `in_we` in 1: instruction writes a register.
- `in_rd` in 5: destination register.
- `in_wb_sel` in 2: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR.
- `in_alu_result`, `in_pc4`, `in_csr_rdata` in XLEN: writeback sources.
- `in_funct3` in 3: load type.
- `in_addr_lo` in 2: load byte offset (ALU result [1:0]).
- `dmem_rvalid` in 1: load response valid.
- `dmem_rdata` in XLEN: aligned 32-bit word containing the load data.
- `flush` in 1: kill the accepted or in-flight instruction.
- `rf_we` out 1, `rf_rd` out 5, `rf_wdata` out XLEN: register-file write port.
- `pend_valid` out 1, `pend_rd` out 5: load in flight, for the hazard unit.
- `load_fault` out 1: one-cycle pulse for a misaligned load or illegal load funct3.

## Operation
- FSM states are IDLE, WAIT and DRAIN.
- **IDLE:**
  - Accept when `in_valid`. Acceptance does not depend on `flush`; `flush` in the acceptance cycle discards the instruction, with no write and no fault.
  - Non-load: next cycle `rf_we = in_we && in_rd != 0`, `rf_rd = in_rd`, `rf_wdata` = selected source. State stays IDLE.
  - Load, legal and aligned: latch rd, we, funct3 and addr_lo, then go to WAIT.
  - Load, faulting: no write; `load_fault` pulses next cycle; state stays IDLE.
    - Faulting funct3: 3, 6, 7.
    - Faulting alignment: LH/LHU with `addr_lo[0]` = 1; LW with `addr_lo` != 0.
- **WAIT:**
  - `pend_valid` = 1 and `pend_rd` = latched rd.
  - `dmem_rvalid` without `flush`: write the extended data next cycle (rd 0 suppressed), then go to IDLE.
  - `flush` without `dmem_rvalid`: go to DRAIN.
  - `flush` together with `dmem_rvalid`: no write; go to IDLE.
- **DRAIN:** wait for `dmem_rvalid`, discard it, go to IDLE. `flush` has no effect here.
- `dmem_rvalid` in IDLE is ignored. Exactly one response is outstanding per accepted load.
- Load extraction:
  - LB/LBU: byte `dmem_rdata[8*addr_lo +: 8]`, sign- or zero-extended.
  - LH/LHU: half `dmem_rdata[16*addr_lo[1] +: 16]`, sign- or zero-extended.
  - LW: the full word.
- `rf_we` is deasserted in every cycle that carries no new write. `rf_rd` and `rf_wdata` hold their last values.

## Timing
- Reset values: state IDLE; `rf_we` 0; `rf_rd` 0; `rf_wdata` 0; `pend_valid` 0; `pend_rd` 0; `load_fault` 0; `in_ready` 1 in the cycle after reset.
- Reset in WAIT or DRAIN returns to IDLE; a later stale `dmem_rvalid` is ignored.
- Non-load latency: accept at edge N, `rf_we` high during cycle N+1, register file commits at the falling edge of N+1.
- Load latency: `dmem_rvalid` sampled at edge M, `rf_we` high during cycle M+1, `in_ready` back to 1 in cycle M+1.
- Minimum load occupancy is 2 cycles; throughput for non-loads is 1 per cycle.
- `load_fault` is registered and asserted in the cycle after acceptance only.

## Structure
- Package `wb_pkg` holds:
  - `wb_sel_e` (ALU, LOAD, PC4, CSR);
  - `wb_state_e` (IDLE, WAIT, DRAIN);
  - funct3 localparams F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5.
- Sub-module `load_align`: purely combinational funct3/addr_lo/rdata → extended XLEN data plus a fault flag. `wb_stage` instantiates it once for the acceptance-time fault check and once on the latched fields for data.

## Test plan
- ALU result 0x0000_1234, rd=5, sel ALU → next cycle rf_we=1, rf_rd=5, rf_wdata=0x0000_1234. Back-to-back ALU op rd=6 value 0x55 → rf_we stays 1 the following cycle.
- LB, addr_lo=3, rvalid two cycles later with rdata=0x80AB_CDEF → in_ready=0 and pend_valid=1, pend_rd=rd while waiting; rf_wdata=0xFFFF_FF80 cycle after rvalid. Same access as LBU → 0x0000_0080.
- LH, addr_lo=2, rdata=0x9234_5678 → 0xFFFF_9234. LW, addr_lo=1 → no write, load_fault pulse, in_ready stays 1.
- ALU write with rd=0, value 0xDEAD_BEEF → rf_we=0. Load to rd=0 → WAIT entered, no write on rvalid.
- Flush in WAIT, rvalid 3 cycles later → DRAIN, response dropped, rf_we never asserted, then IDLE. Flush coincident with rvalid → no write, IDLE next cycle.
- reset_n low during WAIT → all outputs reset. A stale rvalid afterwards in IDLE → no write.
